// File: rtl/aes_sbox_array_if.sv
// Handshake bundle for the multi-lane AES S-box pipeline: input beat, output beat,
// flush control and occupancy status. The DUT binds to 'slave', the producer/consumer to 'master'.
interface aes_sbox_array_if #(
  parameter int NLANES  = 4,
  parameter int LATENCY = 2
) ();
  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic                             in_mode;
  logic [NLANES-1:0]                in_mask;
  logic [8*NLANES-1:0]              in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_mode;
  logic [8*NLANES-1:0]              out_data;
  logic [$clog2(LATENCY+1)-1:0]     occupancy;

  modport slave (
    input  flush, in_valid, in_mode, in_mask, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_mode, in_mask, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, occupancy
  );
endinterface

// File: rtl/aes_sbox_array.sv
// Pipelined multi-lane AES S-box: per-lane forward/inverse substitution ahead of a
// LATENCY-deep elastic valid/ready pipeline with flush and registered occupancy.
module aes_sbox_array #(
  parameter int NLANES  = 4,
  parameter int LATENCY = 2,
  parameter bit INV_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  aes_sbox_array_if.slave   bus
);

  localparam int OCC_W = $clog2(LATENCY + 1);
  localparam int DW    = 8 * NLANES;

  // Entry x lives at bits [8*(255-x) +: 8], i.e. the table reads left-to-right from 0x00.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is derived from the forward one so the two can never disagree.
  function automatic logic [2047:0] invert_table(input logic [2047:0] fwd);
    logic [2047:0] inv;
    logic [7:0]    x;
    logic [7:0]    y;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      y = fwd[{~x, 3'b000} +: 8];
      inv[{~y, 3'b000} +: 8] = x;
    end
    return inv;
  endfunction

  localparam logic [2047:0] SBOX_INV = invert_table(SBOX_FWD);

  function automatic logic [7:0] sbox_lookup(input logic [2047:0] tbl, input logic [7:0] b);
    return tbl[{~b, 3'b000} +: 8];
  endfunction

  logic                 mode_eff;
  logic [DW-1:0]        lut_data;
  logic                 accept;
  logic                 rdy;
  logic [LATENCY-1:0]   stage_ready;
  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [LATENCY-1:0]   mode_q,  mode_d;
  logic [DW-1:0]        data_q [LATENCY];
  logic [DW-1:0]        data_d [LATENCY];
  logic [OCC_W-1:0]     occ_q,   occ_d;

  assign mode_eff = INV_EN ? bus.in_mode : 1'b0;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lut_data = bus.in_data;
    for (int i = 0; i < NLANES; i++) begin
      if (bus.in_mask[i]) begin
        lut_data[8*i +: 8] = mode_eff ? sbox_lookup(SBOX_INV, bus.in_data[8*i +: 8])
                                      : sbox_lookup(SBOX_FWD, bus.in_data[8*i +: 8]);
      end
    end
  end

  // Ready ripples back from the consumer; a stage is free if empty or its successor moves.
  always_comb begin
    rdy         = bus.out_ready;
    stage_ready = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      rdy            = !valid_q[k] || rdy;
      stage_ready[k] = rdy;
    end
  end

  assign bus.in_ready = stage_ready[0] && !bus.flush && rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (stage_ready[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        mode_d[0] = mode_eff;
        data_d[0] = lut_data;
      end
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (stage_ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          mode_d[k] = mode_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
    if (bus.flush) valid_d = '0;
    occ_d = '0;
    for (int k = 0; k < LATENCY; k++) occ_d = occ_d + OCC_W'(valid_d[k]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      mode_q  <= '0;
      occ_q   <= '0;
      // NOTE: data registers are reset as well because out_data must read zero after reset.
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      occ_q   <= occ_d;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= data_d[k];
    end
  end

  assign bus.out_valid = valid_q[LATENCY-1];
  assign bus.out_mode  = mode_q[LATENCY-1];
  assign bus.out_data  = data_q[LATENCY-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_aes_sbox_array.sv
// Directed bench for aes_sbox_array (NLANES=4, LATENCY=2): lookup, latency, masking,
// back-to-back traffic, backpressure, flush and mid-operation reset.
module tb_aes_sbox_array;

  localparam int NLANES  = 4;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  aes_sbox_array_if #(.NLANES(NLANES), .LATENCY(LATENCY)) bus ();

  aes_sbox_array #(.NLANES(NLANES), .LATENCY(LATENCY), .INV_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [3:0] mask, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_mask  = mask;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.out_mode !== 1'b0) begin miscompares++; $display("FAIL rst_out_mode: got %b want 0", bus.out_mode); end
    vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_occupancy: got %0d want 0", bus.occupancy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_forward();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'hFF530100);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fwd_in_ready: got %b want 1", bus.in_ready); end
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_early_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.occupancy !== 2'd1) begin miscompares++; $display("FAIL fwd_occ1: got %0d want 1", bus.occupancy); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'h16ED7C63) begin miscompares++; $display("FAIL fwd_data: got %h want 16ed7c63", bus.out_data); end
    vectors++; if (bus.out_mode !== 1'b0) begin miscompares++; $display("FAIL fwd_mode: got %b want 0", bus.out_mode); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_drained_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL fwd_drained_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_inverse();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 32'h16ED7C63);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL inv_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'hFF530100) begin miscompares++; $display("FAIL inv_data: got %h want ff530100", bus.out_data); end
    vectors++; if (bus.out_mode !== 1'b1) begin miscompares++; $display("FAIL inv_mode: got %b want 1", bus.out_mode); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] din  [4];
    logic [31:0] dexp [4];
    logic        mexp [4];
    int          got;
    din  = '{32'h00010203, 32'h637C777B, 32'h53535353, 32'hEDEDEDED};
    dexp = '{32'h637C777B, 32'h00010203, 32'hEDEDEDED, 32'h53535353};
    mexp = '{1'b0, 1'b1, 1'b0, 1'b1};
    got  = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        drive(1'b1, mexp[c], 4'hF, din[c]);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, bus.in_ready); end
      end else begin
        drive(1'b0, 1'b0, 4'hF, 32'h0);
      end
      tick();
      if (bus.out_valid === 1'b1) begin
        if (got < 4) begin
          vectors++; if (bus.out_data !== dexp[got]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", got, bus.out_data, dexp[got]); end
          vectors++; if (bus.out_mode !== mexp[got]) begin miscompares++; $display("FAIL b2b_mode[%0d]: got %b want %b", got, bus.out_mode, mexp[got]); end
        end
        got++;
      end
    end
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d beats want 4", got); end
  endtask

  task automatic test_mask();
    logic        vm    [4];
    logic [3:0]  vmask [4];
    logic [31:0] vin   [4];
    logic [31:0] vexp  [4];
    int          n;
    vm    = '{1'b0, 1'b0, 1'b1, 1'b1};
    vmask = '{4'b0101, 4'b1010, 4'b0000, 4'b0010};
    vin   = '{32'h00000000, 32'hFF530100, 32'h12345678, 32'h00006300};
    vexp  = '{32'h00630063, 32'h16537C00, 32'h12345678, 32'h00000000};
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      drive(1'b1, vm[v], vmask[v], vin[v]);
      tick();
      drive(1'b0, 1'b0, 4'hF, 32'h0);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++; $display("FAIL mask_timeout[%0d]: out_valid never rose", v);
      end else if (bus.out_data !== vexp[v]) begin
        miscompares++; $display("FAIL mask_data[%0d]: got %h want %h", v, bus.out_data, vexp[v]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seen [$];
    int          acc;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 4'hF, {4{8'(c)}});
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    #1;
    vectors++; if (acc !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("FAIL bp_occ: got %0d want 2", bus.occupancy); end
    vectors++; if (bus.out_data !== 32'h63636363) begin miscompares++; $display("FAIL bp_stable_data: got %h want 63636363", bus.out_data); end
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_follows: got %b want 1", bus.in_ready); end
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid === 1'b1) seen.push_back(bus.out_data);
      tick();
    end
    vectors++;
    if (seen.size() != 2) begin
      miscompares++; $display("FAIL bp_drain_count: got %0d beats want 2", seen.size());
    end else if (seen[0] !== 32'h63636363 || seen[1] !== 32'h7C7C7C7C) begin
      miscompares++; $display("FAIL bp_drain_order: got %h,%h want 63636363,7c7c7c7c", seen[0], seen[1]);
    end
  endtask

  task automatic test_flush();
    int hits;
    hits = 0;
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 32'h01010101);
    tick();
    tick();
    vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("FAIL fl_full_occ: got %0d want 2", bus.occupancy); end
    drive(1'b1, 1'b0, 4'hF, 32'hAAAAAAAA);
    bus.flush = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_in_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL fl_occ: got %0d want 0", bus.occupancy); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid === 1'b1) hits++;
      tick();
    end
    vectors++; if (hits !== 0) begin miscompares++; $display("FAIL fl_leak: got %0d beats want 0", hits); end
    drive(1'b1, 1'b0, 4'hF, 32'h02020202);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    tick();
    bus.flush = 1'b1;
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77777777) begin miscompares++; $display("FAIL fl_hs_beat: got v=%b %h want v=1 77777777", bus.out_valid, bus.out_data); end
    tick();
    bus.flush = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL fl_hs_empty: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 32'h03030303);
    tick();
    tick();
    vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("FAIL rm_full_occ: got %0d want 2", bus.occupancy); end
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    rst = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rm_ready_in_rst: got %b want 0", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL rm_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL rm_occ: got %0d want 0", bus.occupancy); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'h53535353);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0);
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hEDEDEDED) begin miscompares++; $display("FAIL rm_post_data: got v=%b %h want v=1 edededed", bus.out_valid, bus.out_data); end
    tick();
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0);
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_mask();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_sbox_array.md
Name: aes_sbox_array

Overview:
Parametrised, pipelined multi-lane AES S-box unit. It is the successor of the single-byte combinational S-box ROM. Each of NLANES byte lanes is looked up through the forward or inverse S-box, selected per transaction. Data moves through a LATENCY-deep elastic pipeline with valid/ready handshakes on both sides. It sits between the round-state mux and ShiftRows/SubWord logic in the cipher and key-expansion datapaths.

Parameters:
NLANES, 4, number of byte lanes processed per transaction (1..16).
LATENCY, 2, number of register stages from input acceptance to out_valid (1..4).
INV_EN, 1, 1 builds the inverse S-box table; 0 omits it, and in_mode is then treated as 0.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active low
flush  in  1  synchronous clear of all in-flight transactions
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept a transaction this cycle
in_mode  in  1  0 = forward S-box, 1 = inverse S-box
in_mask  in  NLANES  per-lane enable; 0 = byte passes through unchanged
in_data  in  8*NLANES  lane i = bits [8i+7:8i]
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts the output
out_mode  out  1  mode that travelled with the transaction
out_data  out  8*NLANES  substituted bytes
occupancy  out  $clog2(LATENCY+1)  number of valid stages in flight

Behaviour:
- Reset (rst=0 at a clock edge):
  - all stage valid bits, out_valid, out_mode, out_data and occupancy go to 0.
  - in_ready is 0 while rst=0 and 1 on the first cycle after rst is released.
- Lookup:
  - Performed combinationally on the input side, before the stage-0 register.
  - Forward table is the FIPS-197 S-box; inverse table is its exact inverse.
  - Per lane: result = in_mask[i] ? (mode ? InvS(byte) : S(byte)) : byte.
  - Lane results are independent; no cross-lane arithmetic.
- Pipeline:
  - Stages 0..LATENCY-1 each hold {valid, mode, data}.
  - stage_ready[k] = !valid[k] || stage_ready[k+1]; stage_ready[LATENCY] = out_ready.
  - in_ready = stage_ready[0] && !flush.
  - A stage loads from its predecessor when stage_ready[k] is 1. It holds its data when stalled. Its valid clears when it drains with nothing arriving.
  - out_valid, out_mode and out_data are the last stage's contents.
  - Output is stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - A transaction accepted at edge T appears with out_valid=1 after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance, with out_ready held high.
  - Throughput is 1 transaction/cycle.
- Backpressure:
  - With out_ready=0, the unit absorbs exactly LATENCY transactions, then in_ready=0.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Occupancy:
  - Equals the count of set stage valid bits; it is registered, not combinational.
  - Range 0..LATENCY; it never wraps.
- Flush:
  - At the edge where flush=1, all valid bits clear and occupancy goes to 0. Data registers may hold stale values.
  - Flush together with in_valid=1: the input is not accepted (in_ready=0), and nothing enters the pipeline.
  - Flush together with out_valid=1 and out_ready=1: the handshake completes on that edge (the consumer sees the beat), then the pipeline is empty.
- Reset mid-operation:
  - All in-flight transactions are discarded and no partial output is produced.
  - Reset has priority over flush.
- INV_EN=0: in_mode is ignored for lookup; out_mode reports 0.

Test Plan:
1. NLANES=4, LATENCY=2, mode=0, mask=F, in_data=0xFF_53_01_00 -> after 2 cycles out_data=0x16_ED_7C_63, out_mode=0, occupancy returns to 0 one cycle after the output handshake.
2. Mode=1, mask=F, in_data=0x16_ED_7C_63 -> out_data=0xFF_53_01_00. Back-to-back alternating forward/inverse beats at 1/cycle reproduce the original bytes in order.
3. Mask=4'b0101, mode=0, in_data=0x00_00_00_00 -> out_data=0x00_63_00_63.
4. out_ready=0, in_valid held high with 0x00..., 0x01..., 0x02... -> exactly 2 accepted, in_ready=0, occupancy=2, out_data stable at the first result. Raising out_ready drains 63, 7C in order with no loss or duplication.
5. Pipeline full (occupancy=2), assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, and the flushed-cycle input never appears at the output.
6. rst=0 for one edge while occupancy=2 -> out_valid=0, out_data=0, occupancy=0, in_ready=0 during reset; first post-reset input 0x53535353 yields 0xEDEDEDED after 2 cycles.
